// File: rtl/water_pkg.sv
// Shared types and constants for the keypad scanner front end.
package water_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        HELD     = 2'd3
    } scan_state_e;

    // Active-low one-hot column drive patterns.
    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    // Key code is {row_idx[1:0], col_idx[1:0]}.
    localparam int KEY_CODE_W = 4;

    // Column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drive;
        case (idx)
            2'd0:    drive = COL0;
            2'd1:    drive = COL1;
            2'd2:    drive = COL2;
            default: drive = COL3;
        endcase
        return drive;
    endfunction

    // Index of the lowest active-low row; scanning downwards lets the
    // lowest index overwrite higher ones.
    function automatic logic [1:0] decode_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] row_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Resolve metastability over two stages; idle level is all rows high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values and form a real two-flop chain.
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column rotation, row sampling, press/release
// debounce and a single-cycle strobe per accepted key.
module keypad_scanner
    import water_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            row_in,
    output logic [3:0]            col,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]            row_s;
    logic                  row_any_low;
    logic [1:0]            row_idx;
    logic                  tick;

    logic [DIV_W-1:0]      div_q,      div_d;
    logic [1:0]            col_idx_q,  col_idx_d;
    scan_state_e           state_q,    state_d;
    logic [1:0]            cand_row_q, cand_row_d;
    logic [1:0]            cand_col_q, cand_col_d;
    logic [DEB_W-1:0]      deb_cnt_q,  deb_cnt_d;
    logic [DEB_W-1:0]      deb_inc;
    logic                  deb_done;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  key_down_q, key_down_d;

    row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .row_i (row_in),
        .row_o (row_s)
    );

    assign row_any_low = (row_s != 4'hF);
    assign row_idx     = decode_row(row_s);
    assign tick        = (div_q == DIV_W'(SCAN_DIV - 1));
    assign deb_inc     = deb_cnt_q + DEB_W'(1);
    assign deb_done    = (deb_inc == DEB_W'(DEBOUNCE_CNT));

    // Free-running dwell divider; its last count is the sample tick.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Scanner next state: column rotation, candidate latch, debounce counting.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        deb_cnt_d  = deb_cnt_q;
        key_code_d = key_code_q;
        key_down_d = key_down_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (row_any_low) begin
                        // Freeze the column on the detecting one and remember the key.
                        cand_row_d = row_idx;
                        cand_col_d = col_idx_q;
                        deb_cnt_d  = DEB_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_d    = ACCEPT;
                            key_code_d = {row_idx, col_idx_q};
                            key_down_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (row_any_low && (row_idx == cand_row_q)) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            // Code and key_down are loaded on entry so they show during the strobe.
                            state_d    = ACCEPT;
                            key_code_d = {cand_row_q, cand_col_q};
                            key_down_d = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        deb_cnt_d = '0;
                    end
                end
            end

            ACCEPT: begin
                state_d   = HELD;
                deb_cnt_d = '0;
            end

            HELD: begin
                if (tick) begin
                    if (row_any_low) begin
                        deb_cnt_d = '0;
                    end else if (deb_done) begin
                        key_down_d = 1'b0;
                        state_d    = SCAN;
                        col_idx_d  = col_idx_q + 2'd1;
                        deb_cnt_d  = '0;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State registers; reset discards any pending candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            state_q    <= SCAN;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            deb_cnt_q  <= '0;
            key_code_q <= '0;
            key_down_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            state_q    <= state_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            deb_cnt_q  <= deb_cnt_d;
            key_code_q <= key_code_d;
            key_down_q <= key_down_d;
        end
    end

    assign col       = col_drive(col_idx_q);
    assign key_valid = (state_q == ACCEPT);
    assign key_code  = key_code_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) with a
// 4x4 switch-matrix model that pulls a row low while its pressed key's
// column is driven.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;

    logic [3:0][3:0] key_mat = '0;   // key_mat[row][col] = 1 when pressed

    int          cyc;
    int          vcount = 0;
    int          code_bad = 0;
    logic [3:0]  prev_code = 4'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key connects its row to its driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((key_mat[r] & ~col) != 4'h0) row_in[r] = 1'b0;
        end
    end

    // Clocks since reset release: after the k-th rising edge cyc == k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Strobe counter and key_code stability monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid === 1'b1) vcount = vcount + 1;
            if (key_code !== prev_code && key_valid !== 1'b1) code_bad = code_bad + 1;
        end
        prev_code = key_code;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_mat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic test_reset();
        int v0;
        do_reset();
        v0 = vcount;
        n_checks++; if (col !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col); else n_pass++;
        n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", key_valid); else n_pass++;
        n_checks++; if (key_down !== 1'b0) $display("FAIL reset_down: got %b expected 0", key_down); else n_pass++;
        n_checks++; if (key_code !== 4'h0) $display("FAIL reset_code: got %b expected 0000", key_code); else n_pass++;
        wait_cyc(3);
        n_checks++; if (col !== 4'b1110) $display("FAIL idle_col_c3: got %b expected 1110", col); else n_pass++;
        wait_cyc(4);
        n_checks++; if (col !== 4'b1101) $display("FAIL idle_col_c4: got %b expected 1101", col); else n_pass++;
        wait_cyc(8);
        n_checks++; if (col !== 4'b1011) $display("FAIL idle_col_c8: got %b expected 1011", col); else n_pass++;
        wait_cyc(12);
        n_checks++; if (col !== 4'b0111) $display("FAIL idle_col_c12: got %b expected 0111", col); else n_pass++;
        wait_cyc(16);
        n_checks++; if (col !== 4'b1110) $display("FAIL idle_col_c16: got %b expected 1110", col); else n_pass++;
        wait_cyc(24);
        n_checks++; if (vcount - v0 !== 0) $display("FAIL idle_strobes: got %0d expected 0", vcount - v0); else n_pass++;
        n_checks++; if (key_down !== 1'b0 || key_code !== 4'h0) $display("FAIL idle_outputs: got down=%b code=%b expected 0/0000", key_down, key_code); else n_pass++;
    endtask

    task automatic test_stable_press();
        int v0;
        do_reset();
        v0 = vcount;
        key_mat[2][1] = 1'b1;
        wait_cyc(12);
        n_checks++; if (col !== 4'b1101) $display("FAIL press_col_frozen: got %b expected 1101", col); else n_pass++;
        wait_cyc(15);
        n_checks++; if (key_valid !== 1'b0 || key_down !== 1'b0) $display("FAIL press_early: got valid=%b down=%b expected 0/0", key_valid, key_down); else n_pass++;
        wait_cyc(16);
        n_checks++; if (key_valid !== 1'b1) $display("FAIL press_latency: got valid=%b at cyc 16 expected 1", key_valid); else n_pass++;
        n_checks++; if (key_code !== 4'b1001) $display("FAIL press_code: got %b expected 1001", key_code); else n_pass++;
        n_checks++; if (key_down !== 1'b1) $display("FAIL press_down_rise: got %b expected 1", key_down); else n_pass++;
        wait_cyc(17);
        n_checks++; if (key_valid !== 1'b0) $display("FAIL press_width: got %b expected 0", key_valid); else n_pass++;
        wait_cyc(56);
        key_mat = '0;
        wait_cyc(67);
        n_checks++; if (key_down !== 1'b1 || col !== 4'b1101) $display("FAIL release_c67: got down=%b col=%b expected 1/1101", key_down, col); else n_pass++;
        wait_cyc(68);
        n_checks++; if (key_down !== 1'b0 || col !== 4'b1011) $display("FAIL release_c68: got down=%b col=%b expected 0/1011", key_down, col); else n_pass++;
        wait_cyc(72);
        n_checks++; if (col !== 4'b0111) $display("FAIL release_resume: got %b expected 0111", col); else n_pass++;
        n_checks++; if (vcount - v0 !== 1) $display("FAIL press_strobes: got %0d expected 1", vcount - v0); else n_pass++;
    endtask

    task automatic test_bounce();
        int v0;
        do_reset();
        v0 = vcount;
        key_mat[2][1] = 1'b1;
        wait_cyc(8);
        key_mat = '0;
        wait_cyc(10);
        key_mat[2][1] = 1'b1;
        wait_cyc(12);
        n_checks++; if (col !== 4'b1011 || key_down !== 1'b0) $display("FAIL bounce_abort: got col=%b down=%b expected 1011/0", col, key_down); else n_pass++;
        wait_cyc(35);
        n_checks++; if (vcount - v0 !== 0) $display("FAIL bounce_no_strobe: got %0d expected 0", vcount - v0); else n_pass++;
        wait_cyc(36);
        n_checks++; if (key_valid !== 1'b1 || key_code !== 4'b1001) $display("FAIL bounce_accept: got valid=%b code=%b expected 1/1001", key_valid, key_code); else n_pass++;
        wait_cyc(40);
        key_mat = '0;
        wait_cyc(56);
        n_checks++; if (key_down !== 1'b0 || vcount - v0 !== 1) $display("FAIL bounce_release: got down=%b strobes=%0d expected 0/1", key_down, vcount - v0); else n_pass++;
    endtask

    task automatic test_multi_row();
        do_reset();
        key_mat[0][3] = 1'b1;
        key_mat[3][3] = 1'b1;
        wait_cyc(24);
        n_checks++; if (key_valid !== 1'b1) $display("FAIL multi_valid: got %b expected 1", key_valid); else n_pass++;
        n_checks++; if (key_code !== 4'b0011) $display("FAIL multi_code: got %b expected 0011", key_code); else n_pass++;
        wait_cyc(30);
        key_mat = '0;
        wait_cyc(50);
        n_checks++; if (key_down !== 1'b0) $display("FAIL multi_release: got %b expected 0", key_down); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  v0;
        logic ok;
        do_reset();
        v0 = vcount;
        for (int p = 0; p < 5; p++) begin
            key_mat[1][2] = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (key_valid === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_checks++; if (ok !== 1'b1 || key_code !== 4'b0110) $display("FAIL repeat_press_%0d: got seen=%b code=%b expected 1/0110", p, ok, key_code); else n_pass++;
            repeat (12) @(negedge clk);
            key_mat = '0;
            ok = 1'b0;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                if (key_down === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_checks++; if (ok !== 1'b1) $display("FAIL repeat_release_%0d: got key_down=%b expected 0 within 30 clocks", p, key_down); else n_pass++;
            repeat (3) @(negedge clk);
        end
        n_checks++; if (vcount - v0 !== 5) $display("FAIL repeat_count: got %0d expected 5", vcount - v0); else n_pass++;
    endtask

    task automatic test_reset_held();
        int v0;
        do_reset();
        key_mat[2][1] = 1'b1;
        wait_cyc(20);
        n_checks++; if (key_down !== 1'b1) $display("FAIL held_before_rst: got %b expected 1", key_down); else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (key_down !== 1'b0 || col !== 4'b1110) $display("FAIL held_rst_now: got down=%b col=%b expected 0/1110", key_down, col); else n_pass++;
        n_checks++; if (key_code !== 4'h0 || key_valid !== 1'b0) $display("FAIL held_rst_code: got code=%b valid=%b expected 0000/0", key_code, key_valid); else n_pass++;
        key_mat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v0 = vcount;
        repeat (40) @(negedge clk);
        n_checks++; if (vcount - v0 !== 0 || key_down !== 1'b0) $display("FAIL held_after_rst: got strobes=%0d down=%b expected 0/0", vcount - v0, key_down); else n_pass++;
    endtask

    task automatic test_code_stable();
        n_checks++; if (code_bad !== 0) $display("FAIL code_outside_accept: got %0d changes expected 0", code_bad); else n_pass++;
    endtask

    initial begin
        key_mat = '0;
        test_reset();
        test_stable_press();
        test_bounce();
        test_multi_row();
        test_back_to_back();
        test_reset_held();
        test_code_stable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
